// File: rtl/jaxis_ctrl_pkg.sv
// Shared types and constants for the JPEG-encoder AXI-Stream frame sequencer.
package jaxis_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StWaitSof  = 2'd1,
      StCapture  = 2'd2,
      StWaitDone = 2'd3
   } state_e;

   // Bit positions of the sticky error flags within a future status register.
   localparam int unsigned ErrLineLenBit   = 0;
   localparam int unsigned ErrEarlySofBit  = 1;
   localparam int unsigned ErrUnexpDoneBit = 2;
   localparam int unsigned NumErrBits      = 3;

endpackage

// File: rtl/jaxis_frame_ctrl.sv
// Frame gate between the camera AXI-Stream source and the JPEG encoder video slave:
// admits whole frames, latches geometry at frame boundaries and checks it.
module jaxis_frame_ctrl
   import jaxis_ctrl_pkg::*;
#(
   parameter int unsigned SENSOR_X_SIZE = 720,
   parameter int unsigned SENSOR_Y_SIZE = 720,
   parameter int unsigned FCW           = 16,
   localparam int unsigned XW           = $clog2(SENSOR_X_SIZE),
   localparam int unsigned YW           = $clog2(SENSOR_Y_SIZE)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [23:0]   s_axis_video_tdata,
   input  logic          s_axis_video_tvalid,
   output logic          s_axis_video_tready,
   input  logic          s_axis_video_tuser,
   input  logic          s_axis_video_tlast,
   output logic [23:0]   m_axis_video_tdata,
   output logic          m_axis_video_tvalid,
   input  logic          m_axis_video_tready,
   output logic          m_axis_video_tuser,
   output logic          m_axis_video_tlast,
   input  logic          start,
   input  logic          stop,
   input  logic          continuous,
   input  logic [XW-1:0] x_size_m1,
   input  logic [YW-1:0] y_size_m1,
   output logic [XW-1:0] x_size_m1_q,
   output logic [YW-1:0] y_size_m1_q,
   input  logic          enc_done,
   output logic          busy,
   output logic          frame_abort,
   output logic [FCW-1:0] frame_count,
   output logic          err_line_len,
   output logic          err_early_sof,
   output logic          err_unexp_done,
   input  logic          err_clr
);

   state_e         state_q, state_d;
   logic [XW-1:0]  x_cnt_q, x_cnt_d, eff_x;
   logic [YW-1:0]  y_cnt_q, y_cnt_d, eff_y;
   logic           stop_req_q, stop_req_d;
   logic [FCW-1:0] frame_count_d;
   logic           pass, hs, latch, advance, restart;
   logic           line_evt, sof_evt, done_evt;

   always_comb begin
      pass = (state_q == StCapture) || ((state_q == StWaitSof) && s_axis_video_tuser);
      m_axis_video_tdata  = s_axis_video_tdata;
      m_axis_video_tuser  = s_axis_video_tuser;
      m_axis_video_tlast  = s_axis_video_tlast;
      m_axis_video_tvalid = s_axis_video_tvalid & pass;
      s_axis_video_tready = pass ? m_axis_video_tready : 1'b1;
      hs   = s_axis_video_tvalid & s_axis_video_tready;
      busy = (state_q != StIdle);
   end

   always_comb begin
      state_d       = state_q;
      x_cnt_d       = x_cnt_q;
      y_cnt_d       = y_cnt_q;
      stop_req_d    = stop_req_q;
      frame_count_d = frame_count;
      latch         = 1'b0;
      advance       = 1'b0;
      restart       = 1'b0;
      line_evt      = 1'b0;
      sof_evt       = 1'b0;
      done_evt      = enc_done && (state_q != StWaitDone);

      unique case (state_q)
         StIdle: begin
            if (start && !stop) begin
               state_d = StWaitSof;
               latch   = 1'b1;
            end
         end
         StWaitSof: begin
            if (stop) begin
               state_d    = StIdle;
               stop_req_d = 1'b0;
            end else if (hs && s_axis_video_tuser) begin
               state_d = StCapture;
               advance = 1'b1;
               restart = 1'b1;
            end
         end
         StCapture: begin
            if (stop) stop_req_d = 1'b1;
            if (hs) begin
               advance = 1'b1;
               // An SOF with the counters already moving means the source restarted the frame.
               if (s_axis_video_tuser && ((x_cnt_q != '0) || (y_cnt_q != '0))) begin
                  restart = 1'b1;
                  sof_evt = 1'b1;
               end
            end
         end
         StWaitDone: begin
            if (stop) stop_req_d = 1'b1;
            if (enc_done) begin
               frame_count_d = frame_count + 1'b1;
               if (continuous && !stop_req_q && !stop) begin
                  state_d = StWaitSof;
                  latch   = 1'b1;
               end else begin
                  state_d    = StIdle;
                  stop_req_d = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      eff_x = restart ? '0 : x_cnt_q;
      eff_y = restart ? '0 : y_cnt_q;
      if (advance) begin
         if (s_axis_video_tlast) begin
            line_evt = (eff_x != x_size_m1_q);
            x_cnt_d  = '0;
            if (eff_y == y_size_m1_q) state_d = StWaitDone;
            else                      y_cnt_d = eff_y + 1'b1;
         end else begin
            x_cnt_d = (eff_x == '1) ? eff_x : eff_x + 1'b1;
            y_cnt_d = eff_y;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= StIdle;
         x_cnt_q        <= '0;
         y_cnt_q        <= '0;
         x_size_m1_q    <= '0;
         y_size_m1_q    <= '0;
         stop_req_q     <= 1'b0;
         frame_abort    <= 1'b0;
         frame_count    <= '0;
         err_line_len   <= 1'b0;
         err_early_sof  <= 1'b0;
         err_unexp_done <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_cnt_q     <= x_cnt_d;
         y_cnt_q     <= y_cnt_d;
         stop_req_q  <= stop_req_d;
         frame_abort <= sof_evt;
         frame_count <= frame_count_d;
         if (latch) begin
            x_size_m1_q <= x_size_m1;
            y_size_m1_q <= y_size_m1;
         end
         // A new error event in the same cycle as err_clr keeps the flag set.
         err_line_len   <= (err_line_len   & ~err_clr) | line_evt;
         err_early_sof  <= (err_early_sof  & ~err_clr) | sof_evt;
         err_unexp_done <= (err_unexp_done & ~err_clr) | done_evt;
      end
   end

endmodule
